fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch front end that sits directly upstream of the two-stage pipeline's first forwarding register. It owns the fetch PC, issues word requests to instruction memory, and buffers returned instructions with their PCs in a small in-order queue. It presents them to the decode stage over a valid/ready handshake and flushes cleanly on a taken branch from the execute stage.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  word address, bits [1:0] always 0
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response valid, exactly one cycle after the accepting edge
- imem_rsp_inst  in  32  returned instruction
- br_taken  in  1  redirect request from execute
- br_target  in  32  redirect address; bits [1:0] ignored (forced 0)
- out_valid  out  1  queue head valid
- out_pc  out  32  PC of head entry
- out_inst  out  32  instruction of head entry
- out_ready  in  1  decode consumes head (deasserted on stall)
- rsp_err  out  1  sticky: response arrived with no request pending

## Operation
- State: fetch_pc (32), pending (1), pending_pc (32), drop (1), queue of DEPTH × {pc, inst}, rd_ptr, wr_ptr, count (0..DEPTH).
- Request: imem_req_valid = !br_taken && (count + pending) < DEPTH; imem_req_addr = fetch_pc.
- Accept (req_valid && req_ready): pending←1, pending_pc←fetch_pc, drop←0, fetch_pc←fetch_pc+4 (wraps modulo 2^32).
- Response with pending=1: pending←0; if drop=0, push {pending_pc, imem_rsp_inst}; if drop=1, discard.
- Response with pending=0: discard, rsp_err←1 (cleared only by reset).
- Pop: out_valid && out_ready advances rd_ptr.
- Push and pop in the same cycle: both occur, count unchanged.
- Redirect (br_taken=1) has priority over everything except reset:
  - Queue flushed: count←0, rd_ptr←wr_ptr←0.
  - fetch_pc←{br_target[31:2],2'b00}; no request issued this cycle.
  - Pending fetch becomes drop←1, so its response is discarded.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the same cycle is ignored.
- Slot accounting (count + pending < DEPTH) guarantees push never overflows; no full-drop path exists.
- out_pc/out_inst are don't-care when out_valid=0.

## Timing
- Reset asserted: imem_req_valid=0, out_valid=0, rsp_err=0, pending=0, drop=0, count=0, fetch_pc=RESET_PC, pointers 0. imem_req_valid stays 0 while reset is low, even though the request formula would otherwise be true.
- First cycle after reset release: imem_req_valid=1, addr=RESET_PC.
- Latency: request accepted at edge k, response sampled at edge k+1, out_valid=1 from edge k+1. Request-to-head latency is 2 cycles.
- Throughput: one instruction per cycle sustained when req_ready=1 and out_ready=1 (count+pending ≤ 2 < DEPTH).
- Redirect at edge r: first target request at cycle after r, first target instruction at out from r+2. out_valid=0 for cycles r..r+1.
- Reset mid-operation: all state clears asynchronously; in-flight response after release is flagged by rsp_err unless the memory is also reset.
- out_valid, out_pc, out_inst come from registers only; there is no combinational path from imem_rsp_* to out_*.

## Test plan
- Reset, then req_ready=1, out_ready=1, memory returns inst=addr^32'hA5A5_0000 → out sequence pc 0,4,8,… one per cycle, first out_valid 2 cycles after reset release.
- out_ready=0 for 10 cycles → count reaches 4, req_valid drops when count+pending=4, no entry lost. Release → pcs remain contiguous.
- br_taken with target 32'h0000_0103 while a fetch is pending → pending response discarded, queue empty, next request addr=32'h100, out pc 0x100 two cycles later.
- req_ready toggling 1,0,0,1 → addresses issued without gaps or duplicates; out pcs contiguous.
- Full queue with out_ready=1 and a response arriving the same cycle → push and pop both occur, count constant, order preserved.
- imem_rsp_valid pulsed with no request pending → rsp_err=1 and stays 1; reset low mid-stream → all outputs 0 and next fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory request/response, branch redirect
// and the decode-side valid/ready head port, seen from the fetch unit (master).
interface fetch_queue_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_inst;
    logic        br_taken;
    logic [31:0] br_target;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic        rsp_err;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_inst,
        input  br_taken, br_target,
        output out_valid, out_pc, out_inst,
        input  out_ready,
        output rsp_err
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_inst,
        output br_taken, br_target,
        input  out_valid, out_pc, out_inst,
        output out_ready,
        input  rsp_err
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, keeps at most one memory
// request in flight and buffers returned instructions in an in-order queue.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst_n,
    fetch_queue_if.master bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW:0]   DEPTH_L  = (CW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   pending_pc_r;
    logic          pending_r;
    logic          drop_r;
    logic          rsp_err_r;
    logic [31:0]   q_pc_r   [DEPTH];
    logic [31:0]   q_inst_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;

    logic [CW:0]   used_s;
    logic          req_valid_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic          head_valid_s;

    // Slot accounting: an in-flight request reserves a queue slot, so a push can never overflow.
    always_comb begin
        used_s       = {1'b0, count_r} + {{CW{1'b0}}, pending_r};
        head_valid_s = (count_r != CNT_ZERO);
        if (rst_n && !bus.br_taken && (used_s < DEPTH_L)) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
        accept_s = req_valid_s && bus.imem_req_ready;
        push_s   = !bus.br_taken && bus.imem_rsp_valid && pending_r && !drop_r;
        pop_s    = !bus.br_taken && head_valid_s && bus.out_ready;
    end

    // Fetch PC, in-flight tracking and queue state; a redirect overrides all but reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r   <= RESET_PC;
            pending_pc_r <= 32'h0000_0000;
            pending_r    <= 1'b0;
            drop_r       <= 1'b0;
            rsp_err_r    <= 1'b0;
            rd_ptr_r     <= PTR_ZERO;
            wr_ptr_r     <= PTR_ZERO;
            count_r      <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_r[i]   <= 32'h0000_0000;
                q_inst_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (bus.br_taken) begin
                fetch_pc_r <= {bus.br_target[31:2], 2'b00};
                rd_ptr_r   <= PTR_ZERO;
                wr_ptr_r   <= PTR_ZERO;
                count_r    <= CNT_ZERO;
                drop_r     <= 1'b1;
                if (bus.imem_rsp_valid) begin
                    pending_r <= 1'b0;
                end else begin
                    pending_r <= pending_r;
                end
            end else begin
                if (accept_s) begin
                    pending_r    <= 1'b1;
                    pending_pc_r <= fetch_pc_r;
                    drop_r       <= 1'b0;
                    fetch_pc_r   <= fetch_pc_r + 32'd4;
                end else if (bus.imem_rsp_valid) begin
                    pending_r <= 1'b0;
                end else begin
                    pending_r <= pending_r;
                end
                if (push_s) begin
                    q_pc_r[wr_ptr_r]   <= pending_pc_r;
                    q_inst_r[wr_ptr_r] <= bus.imem_rsp_inst;
                    wr_ptr_r           <= wr_ptr_r + PTR_ONE;
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
            // A response nobody asked for is a protocol error that stays visible until reset.
            if (bus.imem_rsp_valid && !pending_r) begin
                rsp_err_r <= 1'b1;
            end else begin
                rsp_err_r <= rsp_err_r;
            end
        end
    end

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.out_valid      = head_valid_s;
    assign bus.out_pc         = q_pc_r[rd_ptr_r];
    assign bus.out_inst       = q_inst_r[rd_ptr_r];
    assign bus.rsp_err        = rsp_err_r;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomised scoreboard bench for fetch_queue: a memory model answers each
// accepted request one cycle later; expected head entries are queued and checked.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic clk;
    logic rst_n;
    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_addr;
    logic        acc_q;
    logic [31:0] addr_q;
    logic        err_m;
    logic        real_rsp;
    logic        exp_rv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and reference model: evaluated mid-cycle, describes what the next edge must do.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_addr = RESET_PC;
            acc_q    = 1'b0;
            addr_q   = 32'h0;
            err_m    = 1'b0;
        end else begin
            real_rsp = acc_q;
            exp_rv   = !bus.br_taken && ((exp_q.size() + int'(real_rsp)) < DEPTH);
            chk("req_valid", {31'h0, bus.imem_req_valid}, {31'h0, exp_rv});
            if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_addr);
            chk("out_valid", {31'h0, bus.out_valid}, {31'h0, (exp_q.size() != 0)});
            if (bus.out_valid && exp_q.size() != 0) begin
                chk("out_pc", bus.out_pc, exp_q[0][63:32]);
                chk("out_inst", bus.out_inst, exp_q[0][31:0]);
            end
            chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, err_m});
            if (bus.br_taken) begin
                exp_q.delete();
                exp_addr = {bus.br_target[31:2], 2'b00};
            end else begin
                if (bus.out_valid && bus.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (real_rsp) exp_q.push_back({addr_q, addr_q ^ KEY});
                if (bus.imem_req_valid && bus.imem_req_ready) exp_addr = exp_addr + 32'd4;
            end
            if (bus.imem_rsp_valid && !real_rsp) err_m = 1'b1;
            acc_q  = bus.imem_req_valid && bus.imem_req_ready;
            addr_q = bus.imem_req_addr;
        end
    end

    task automatic step(input logic rr, input logic ordy, input logic br,
                        input logic [31:0] tgt, input logic spur);
        @(posedge clk);
        #1;
        bus.imem_req_ready = rr;
        bus.out_ready      = ordy;
        bus.br_taken       = br;
        bus.br_target      = tgt;
        if (acc_q) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_inst  = addr_q ^ KEY;
        end else begin
            bus.imem_rsp_valid = spur;
            bus.imem_rsp_inst  = $urandom;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n              = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        bus.br_taken       = 1'b0;
        #1;
        chk("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        chk("rst_addr", bus.imem_req_addr, RESET_PC);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_inst  = 32'h0;
        bus.br_taken       = 1'b0;
        bus.br_target      = 32'h0;
        bus.out_ready      = 1'b0;
        do_reset();

        // Streaming at full rate.
        repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        // Decode stall fills the queue, then drains.
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect while the response of a pending fetch is on the bus.
        for (int i = 0; i < 10 && !acc_q; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("pending_before_br", {31'h0, acc_q}, 32'h1);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Memory back-pressure pattern.
        for (int i = 0; i < 16; i++) step((i % 4 == 0) || (i % 4 == 3), 1'b1, 1'b0, 32'h0, 1'b0);

        // Full queue with pop and push in the same cycle.
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Spurious response.
        repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Random mix of stalls, redirects and stray responses.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 31) == 0);
        end

        // Reset mid-stream, then resume.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom, 1'b0);
        end
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
